// File: rtl/matmul_c_streamer.sv
// Streams the N x N result matrix out of BRAM C in row-major order on a
// valid/ready port, using a 2-entry skid buffer so full backpressure costs no throughput.
module matmul_c_streamer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int MATRIX_SIZE = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [1:0]            state_dbg
);

    localparam int TOTAL = MATRIX_SIZE * MATRIX_SIZE;
    localparam int CW    = $clog2(TOTAL) + 1;
    localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

    generate
        if (longint'(TOTAL) > (longint'(1) << ADDR_WIDTH)) begin : g_addr_check
            $error("matmul_c_streamer: MATRIX_SIZE*MATRIX_SIZE exceeds the BRAM C address space");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           rd_idx, sent;
    logic                    inflight;
    logic [1:0]              count;
    logic [DATA_WIDTH-1:0]   head, tail;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    pop, push, issue, accept;
    logic [2:0]              level;

    // Stream handshake: a word transfers on every rising edge where
    // out_valid and out_ready are both high; out_data/out_last hold while stalled.
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign out_last  = out_valid && (sent == LAST_IDX);
    assign pop       = out_valid & out_ready;
    assign push      = inflight;
    assign level     = {1'b0, count} + {2'b00, inflight};
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        done       = 1'b0;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // Reads in flight plus buffered words must fit the 2-entry buffer after this pop.
                issue = (rd_idx < TOTAL_C) && (level < (3'd2 + {2'b00, pop}));
                if (pop && (sent == LAST_IDX)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign c_addr = issue ? ADDR_WIDTH'(rd_idx) : addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_idx   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
            addr_q   <= '0;
        end else begin
            inflight <= issue;
            addr_q   <= c_addr;
            if (accept) begin
                rd_idx <= '0;
                sent   <= '0;
            end else begin
                if (issue) rd_idx <= rd_idx + CW'(1);
                if (pop)   sent   <= sent + CW'(1);
            end
        end
    end

    // head is the presented word; tail only holds data while two words are buffered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= c_dout;
                    else               tail <= c_dout;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= c_dout;
                    end else begin
                        head <= tail;
                        tail <= c_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_c_streamer.sv
// Bench for matmul_c_streamer: a queue-based model of the expected word stream
// checked every cycle, plus directed cycle-exact expectations for each scenario.
module tb_matmul_c_streamer;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int N  = 8;
    localparam int NN = N * N;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // main DUT (N = 8)
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, out_valid, out_last;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_dout = '0;
    logic [DW-1:0] out_data;
    logic [1:0]    state_dbg;

    // small DUT (N = 2)
    logic          start2 = 1'b0;
    logic          ready2 = 1'b1;
    logic          busy2, done2, valid2, last2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] dout2 = '0;
    logic [DW-1:0] data2;
    logic [1:0]    state2;

    matmul_c_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(N)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .c_addr(c_addr), .c_dout(c_dout), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .state_dbg(state_dbg)
    );

    matmul_c_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .c_addr(addr2), .c_dout(dout2), .out_data(data2), .out_valid(valid2),
        .out_ready(ready2), .out_last(last2), .state_dbg(state2)
    );

    // BRAM C models, 1-cycle synchronous read
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clock) c_dout <= bram[c_addr];
    always @(posedge clock) dout2 <= DW'(addr2) + 32'd500;

    logic rand_mode = 1'b0;
    always @(negedge clock) if (rand_mode) out_ready = 1'($urandom_range(0, 1));

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // scoreboard / model state
    logic [DW-1:0] exp_q[$];
    logic          m_busy = 1'b0;
    logic          m_done_due = 1'b0;
    logic          stall = 1'b0;
    logic [DW-1:0] held = '0;
    logic          acc, nd;
    int            word_cnt, last_cnt, done_cnt;
    int            first_valid_cyc, last_cyc, done_cyc, busy_first, busy_last;
    logic [DW-1:0] first_data, last_data;

    task automatic clear_stats();
        word_cnt = 0; last_cnt = 0; done_cnt = 0;
        first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
        busy_first = -1; busy_last = -1;
        first_data = '0; last_data = '0;
    endtask

    // compare process: cycle number 0 is the cycle in which start is accepted
    always begin
        @(negedge clock);
        #2;
        cyc++;
        if (reset) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_out_last", out_last, 0);
            exp_q.delete();
            m_busy = 1'b0;
            m_done_due = 1'b0;
            stall = 1'b0;
        end else begin
            check("busy", busy, m_busy);
            check("done", done, m_done_due);
            if (busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_word: got %0d, expected no word (cycle %0d)", out_data, cyc);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    check("out_last", out_last, exp_q.size() == 1);
                end
                if (first_valid_cyc < 0) begin
                    first_valid_cyc = cyc;
                    first_data = out_data;
                end
                if (out_last) begin
                    last_cnt++;
                    last_cyc = cyc;
                    last_data = out_data;
                end
            end else begin
                check("last_idle", out_last, 0);
            end
            nd = 1'b0;
            if (out_valid && out_ready) begin
                word_cnt++;
                if (exp_q.size() > 0) begin
                    if (exp_q.size() == 1) nd = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            stall = out_valid && !out_ready;
            held  = out_data;
            acc   = start && !m_busy;
            if (m_done_due) m_busy = 1'b0;
            if (acc) begin
                m_busy = 1'b1;
                cyc = 0;
                for (int k = 0; k < NN; k++) exp_q.push_back(bram[k]);
            end
            m_done_due = nd;
        end
    end

    // driver tasks
    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        checks++;
        if (done_cnt != 0) passed++;
        else $display("FAIL done_timeout: got no done, expected done within %0d cycles", budget);
    endtask

    task automatic run_small();
        @(negedge clock);
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #3;
            check("n2_valid", valid2, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check("n2_data", data2, 500 + c - 3);
            check("n2_last", last2, c == 6);
            check("n2_done", done2, c == 7);
            check("n2_busy", busy2, c <= 7);
            @(negedge clock);
        end
    endtask

    initial begin
        for (int k = 0; k < (1 << AW); k++) bram[k] = DW'(k + 100);
        clear_stats();
        repeat (3) @(negedge clock);
        #1;
        check("rst_c_addr", c_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_state", state_dbg, 0);
        check("rst_n2_valid", valid2, 0);
        check("rst_n2_state", state2, 0);
        reset = 1'b0;

        // full throughput
        out_ready = 1'b1;
        clear_stats();
        pulse_start();
        wait_done(200);
        check("t1_first_cyc", first_valid_cyc, 3);
        check("t1_first_data", first_data, 100);
        check("t1_last_cyc", last_cyc, 66);
        check("t1_last_data", last_data, 163);
        check("t1_last_cnt", last_cnt, 1);
        check("t1_done_cyc", done_cyc, 67);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_words", word_cnt, 64);
        check("t1_busy_first", busy_first, 1);
        check("t1_busy_last", busy_last, 67);

        // backpressure: ready low through cycle 10
        out_ready = 1'b0;
        clear_stats();
        pulse_start();
        repeat (2) @(negedge clock);
        #3;
        check("t2_c3_valid", out_valid, 1);
        check("t2_c3_data", out_data, 100);
        repeat (7) @(negedge clock);
        #3;
        check("t2_c10_valid", out_valid, 1);
        check("t2_c10_data", out_data, 100);
        @(negedge clock);
        out_ready = 1'b1;
        wait_done(200);
        check("t2_words", word_cnt, 64);
        check("t2_last_cyc", last_cyc, 74);
        check("t2_done_cyc", done_cyc, 75);
        check("t2_last_cnt", last_cnt, 1);

        // random ready with random matrix contents
        for (int k = 0; k < NN; k++) bram[k] = $urandom;
        clear_stats();
        rand_mode = 1'b1;
        pulse_start();
        wait_done(2000);
        rand_mode = 1'b0;
        out_ready = 1'b1;
        check("t3_words", word_cnt, 64);
        check("t3_last_cnt", last_cnt, 1);
        check("t3_done_cnt", done_cnt, 1);
        for (int k = 0; k < NN; k++) bram[k] = DW'(k + 100);

        // second start at cycle 20 is ignored
        clear_stats();
        pulse_start();
        repeat (19) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(200);
        check("t4_words", word_cnt, 64);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_done_cyc", done_cyc, 67);
        clear_stats();
        pulse_start();
        wait_done(200);
        check("t4b_words", word_cnt, 64);
        check("t4b_first_cyc", first_valid_cyc, 3);
        check("t4b_done_cnt", done_cnt, 1);

        // reset at cycle 30
        clear_stats();
        pulse_start();
        repeat (29) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t5_valid_now", out_valid, 0);
        check("t5_busy_now", busy, 0);
        check("t5_done_now", done, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("t5_no_done", done_cnt, 0);
        clear_stats();
        pulse_start();
        wait_done(200);
        check("t5_words", word_cnt, 64);
        check("t5_first_data", first_data, 100);
        check("t5_first_cyc", first_valid_cyc, 3);
        check("t5_done_cnt", done_cnt, 1);

        // MATRIX_SIZE = 2 instance
        run_small();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
